// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the memory-stage data-access unit.
package mem_pkg;

  typedef enum logic [1:0] {MS_IDLE, MS_REQ, MS_DONE} mem_state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam int         LANES   = 4;
  localparam int         LANE_W  = 8;

  // One-hot byte enable for a byte access at address offset off.
  function automatic logic [3:0] lane_onehot(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replication and load byte select with zero-extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        byte_access,
  input  logic [1:0]  store_off,
  input  logic [31:0] store_data,
  input  logic        load_byte,
  input  logic [1:0]  load_off,
  input  logic [31:0] load_raw,
  output logic [3:0]  be_next,
  output logic [31:0] wdata_next,
  output logic [31:0] load_next
);

  logic [LANE_W-1:0] rd_byte [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign rd_byte[gi] = load_raw[LANE_W*gi +: LANE_W];
      // Byte stores replicate the low byte so any lane carries it.
      assign wdata_next[LANE_W*gi +: LANE_W] =
        byte_access ? store_data[LANE_W-1:0] : store_data[LANE_W*gi +: LANE_W];
    end
  endgenerate

  always_comb begin
    be_next   = byte_access ? lane_onehot(store_off) : BE_WORD;
    load_next = load_byte ? {24'h000000, rd_byte[load_off]} : load_raw;
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-stage access unit: issues one handshaked bus access per load/store, stalls
// the pipeline until DAck or timeout, and returns aligned load data.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemReadM,
  input  logic          MemWriteM,
  input  logic          ByteM,
  input  logic [31:0]   ALUResultM,
  input  logic [31:0]   WriteDataM,
  output logic [31:0]   ReadDataM,
  output logic          StallM,
  output logic          BusErrM,
  output logic          DReq,
  output logic          DWe,
  output logic [AW-1:0] DAddr,
  output logic [3:0]    DBe,
  output logic [31:0]   DWData,
  input  logic [31:0]   DRData,
  input  logic          DAck
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          byte_reg;
  logic [1:0]    off_reg;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [31:0]   load_next;

  mem_lane_align u_align (
    .byte_access (ByteM),
    .store_off   (ALUResultM[1:0]),
    .store_data  (WriteDataM),
    .load_byte   (byte_reg),
    .load_off    (off_reg),
    .load_raw    (DRData),
    .be_next     (be_next),
    .wdata_next  (wdata_next),
    .load_next   (load_next)
  );

  // Stall is combinational so the issuing cycle already freezes the pipeline.
  always_comb begin
    StallM = reset & (((state_reg == MS_IDLE) & (MemReadM | MemWriteM)) |
                      (state_reg == MS_REQ));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= MS_IDLE;
      cnt_reg   <= '0;
      byte_reg  <= 1'b0;
      off_reg   <= 2'b00;
      DReq      <= 1'b0;
      DWe       <= 1'b0;
      DAddr     <= '0;
      DBe       <= 4'b0000;
      DWData    <= 32'h0;
      ReadDataM <= 32'h0;
      BusErrM   <= 1'b0;
    end else begin
      BusErrM <= 1'b0;
      case (state_reg)
        MS_IDLE: begin
          if (MemReadM | MemWriteM) begin
            DReq      <= 1'b1;
            DWe       <= MemWriteM;
            DAddr     <= {ALUResultM[AW-1:2], 2'b00};
            DBe       <= be_next;
            DWData    <= wdata_next;
            byte_reg  <= ByteM;
            off_reg   <= ALUResultM[1:0];
            cnt_reg   <= '0;
            state_reg <= MS_REQ;
          end
        end
        MS_REQ: begin
          // DAck is tested first so a completion on the last allowed cycle is not an error.
          if (DAck) begin
            DReq      <= 1'b0;
            ReadDataM <= DWe ? 32'h0 : load_next;
            state_reg <= MS_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            DReq      <= 1'b0;
            ReadDataM <= 32'h0;
            BusErrM   <= 1'b1;
            state_reg <= MS_DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        MS_DONE: state_reg <= MS_IDLE;
        default: state_reg <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level reference model.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, ByteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, BusErrM, DReq, DWe;
  logic [31:0] DAddr;
  logic [3:0]  DBe;
  logic [31:0] DWData, DRData;
  logic        DAck;

  mem_access_stage #(.TIMEOUT(TO), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ByteM      (ByteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .BusErrM    (BusErrM),
    .DReq       (DReq),
    .DWe        (DWe),
    .DAddr      (DAddr),
    .DBe        (DBe),
    .DWData     (DWData),
    .DRData     (DRData),
    .DAck       (DAck)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic        chk_en  = 1'b0;
  logic        chk_bus = 1'b0;
  logic        exp_stall, exp_dreq, exp_err, exp_we;
  logic [31:0] exp_rd, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] rd_last;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: what the bus and result must look like for one access.
  function automatic logic [31:0] m_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [3:0] m_be(input bit bt, input logic [31:0] a);
    if (!bt) return 4'hF;
    case (a[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input bit bt, input logic [31:0] w);
    return bt ? {4{w[7:0]}} : w;
  endfunction

  function automatic logic [31:0] m_load(input bit bt, input logic [31:0] a, input logic [31:0] r);
    return bt ? ((r >> (8 * a[1:0])) & 32'h0000_00FF) : r;
  endfunction

  // Single compare process: every cycle, DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("StallM", 32'(StallM), 32'(exp_stall));
      chk("DReq", 32'(DReq), 32'(exp_dreq));
      chk("BusErrM", 32'(BusErrM), 32'(exp_err));
      chk("ReadDataM", ReadDataM, exp_rd);
      if (chk_bus) begin
        chk("DWe", 32'(DWe), 32'(exp_we));
        chk("DAddr", DAddr, exp_addr);
        chk("DBe", 32'(DBe), 32'(exp_be));
        chk("DWData", DWData, exp_wdata);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      MemReadM = 1'b0; MemWriteM = 1'b0;
      ByteM = 1'($urandom); ALUResultM = $urandom; WriteDataM = $urandom;
      DAck = 1'($urandom_range(0, 1)); DRData = $urandom;
      exp_stall = 1'b0; exp_dreq = 1'b0; exp_err = 1'b0; exp_rd = rd_last; chk_bus = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
    end
    DAck = 1'b0;
  endtask

  // One access; DAck arrives d cycles after DReq rises (d >= TO means never).
  task automatic do_op(input bit rd, input bit wr, input bit bt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int d,
                       output int stalls, output int dreqs, output logic [3:0] be_o,
                       output logic [31:0] addr_o, output logic [31:0] wd_o,
                       output logic [31:0] rdm, output bit err);
    bit acked;
    logic [31:0] res;
    stalls = 0; dreqs = 0; be_o = 4'h0; addr_o = 32'h0; wd_o = 32'h0;
    MemReadM = rd; MemWriteM = wr; ByteM = bt; ALUResultM = addr; WriteDataM = wdata;
    DAck = 1'b0; DRData = $urandom;
    exp_stall = 1'b1; exp_dreq = 1'b0; exp_err = 1'b0; exp_rd = rd_last; chk_bus = 1'b0;
    exp_we = wr; exp_addr = m_addr(addr); exp_be = m_be(bt, addr); exp_wdata = m_wdata(bt, wdata);
    @(negedge clk);
    stalls += int'(StallM); dreqs += int'(DReq);
    for (int j = 0; j < TO; j++) begin
      @(posedge clk); #1;
      DAck = (j == d);
      DRData = (j == d) ? rdata : $urandom;
      exp_stall = 1'b1; exp_dreq = 1'b1; chk_bus = 1'b1;
      @(negedge clk);
      stalls += int'(StallM); dreqs += int'(DReq);
      if (j == 0) begin be_o = DBe; addr_o = DAddr; wd_o = DWData; end
      if (j == d) break;
    end
    acked = (d >= 0) && (d < TO);
    res = wr ? 32'h0 : (acked ? m_load(bt, addr, rdata) : 32'h0);
    @(posedge clk); #1;
    DAck = 1'b0; DRData = $urandom;
    rd_last = res; exp_rd = res; exp_err = !acked;
    exp_stall = 1'b0; exp_dreq = 1'b0; chk_bus = 1'b0;
    @(negedge clk);
    stalls += int'(StallM); dreqs += int'(DReq);
    rdm = ReadDataM; err = BusErrM;
    @(posedge clk); #1;
    exp_err = 1'b0;
    $display("op rd=%0b wr=%0b byte=%0b addr=%h d=%0d -> ReadDataM=%h BusErrM=%0b stall=%0d",
             rd, wr, bt, addr, d, rdm, err, stalls);
  endtask

  // Reset during REQ, followed by a late DAck that must be ignored.
  task automatic reset_mid_access();
    MemReadM = 1'b1; MemWriteM = 1'b0; ByteM = 1'b0; ALUResultM = 32'h0000_0800;
    WriteDataM = 32'h0; DAck = 1'b0; DRData = $urandom;
    exp_stall = 1'b1; exp_dreq = 1'b0; exp_err = 1'b0; exp_rd = rd_last; chk_bus = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    exp_dreq = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0; MemReadM = 1'b0;
    exp_stall = 1'b0; exp_dreq = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1; DAck = 1'b1; DRData = 32'h5555_5555;
    rd_last = 32'h0; exp_rd = 32'h0; exp_dreq = 1'b0; exp_stall = 1'b0;
    chk_bus = 1'b1; exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
    DAck = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    chk_bus = 1'b0;
    $display("op reset during REQ, late DAck -> ReadDataM=%h DReq=%0b", ReadDataM, DReq);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, dq;
    logic [3:0] be;
    logic [31:0] ad, wd, rdm;
    bit er;

    reset = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; DRData = 32'h0; DAck = 1'b0;
    rd_last = 32'h0;
    @(posedge clk); #1;
    // Held in reset with a load requested: no stall, everything cleared.
    MemReadM = 1'b1;
    exp_stall = 1'b0; exp_dreq = 1'b0; exp_err = 1'b0; exp_rd = 32'h0;
    chk_bus = 1'b1; exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
    chk_en = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, st, dq, be, ad, wd, rdm, er);
    chk("t1_stall", 32'(st), 32'd2);
    chk("t1_dreq", 32'(dq), 32'd1);
    chk("t1_addr", ad, 32'h0000_0100);
    chk("t1_be", 32'(be), 32'hF);
    chk("t1_rdata", rdm, 32'hDEAD_BEEF);
    idle(1);

    do_op(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h1234_56AB, 32'hFFFF_FFFF, 2, st, dq, be, ad, wd, rdm, er);
    chk("t2_stall", 32'(st), 32'd4);
    chk("t2_addr", ad, 32'h0000_0200);
    chk("t2_be", 32'(be), 32'h8);
    chk("t2_wdata", wd, 32'hABAB_ABAB);
    chk("t2_rdata", rdm, 32'h0);
    idle(1);

    do_op(1'b1, 1'b0, 1'b1, 32'h0000_0101, 32'h0, 32'h1122_3344, 0, st, dq, be, ad, wd, rdm, er);
    chk("t3_rdata", rdm, 32'h0000_0033);
    idle(1);

    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 99, st, dq, be, ad, wd, rdm, er);
    chk("t4_dreq", 32'(dq), 32'd16);
    chk("t4_err", 32'(er), 32'd1);
    chk("t4_rdata", rdm, 32'h0);
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0404, 32'h0, 32'h0BAD_C0DE, TO - 1, st, dq, be, ad, wd, rdm, er);
    chk("t4b_dreq", 32'(dq), 32'd16);
    chk("t4b_err", 32'(er), 32'd0);
    chk("t4b_rdata", rdm, 32'h0BAD_C0DE);
    idle(1);

    reset_mid_access();
    chk("t5_rdata", ReadDataM, 32'h0);
    chk("t5_dreq", 32'(DReq), 32'd0);
    idle(1);

    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0102_0304, 0, st, dq, be, ad, wd, rdm, er);
    do_op(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'hA5A5_5A5A, 32'h0, 1, st, dq, be, ad, wd, rdm, er);
    chk("t6_dreq", 32'(dq), 32'd2);
    chk("t6_stall", 32'(st), 32'd3);
    chk("t6_wdata", wd, 32'hA5A5_5A5A);
    idle(1);

    for (int k = 0; k < 150; k++) begin
      int sel, p, d;
      bit rd, wr;
      sel = $urandom_range(0, 9);
      rd = (sel <= 4) || (sel == 9);
      wr = (sel >= 5);
      p = $urandom_range(0, 19);
      d = (p == 0) ? 20 : (p == 1) ? TO - 1 : $urandom_range(0, 4);
      do_op(rd, wr, 1'($urandom), $urandom, $urandom, $urandom, d, st, dq, be, ad, wd, rdm, er);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
